// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and
// word-alignment constants.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] ALIGN_MASK = 32'(WORD_BYTES - 1);

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr & ALIGN_MASK) == '0;
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Single-word load/store unit: computes base+imm, rejects misaligned
// addresses, performs one memory handshake with a bounded wait, pulses done.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Last counter value before the wait budget is exhausted.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_store_q, is_store_d;
  logic        err_q, err_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] eff_addr;

  assign eff_addr = base + imm;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_store_d = is_store_q;
    err_d      = err_q;
    wait_d     = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d     = eff_addr;
          wdata_d    = wdata;
          is_store_d = is_store;
          wait_d     = '0;
          if (!word_aligned(eff_addr)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // An ack in the final budgeted cycle still completes successfully.
        if (mem_ack) begin
          if (!is_store_q) rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_store_q <= is_store_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = done && err_q;
  assign mem_req   = (state_q == ST_ACCESS);
  assign mem_we    = mem_req && is_store_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and random transactions
// checked against a transaction-level latency/result model.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset, start, is_store;
  logic [31:0] base, imm, wdata, mem_rdata;
  logic        mem_ack;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] model_rdata = '0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .base(base), .imm(imm), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction. ack_delay = number of ACCESS cycles before the ack.
  task automatic run_txn(input logic st, input logic [31:0] b, input logic [31:0] i,
                         input logic [31:0] wd, input int ack_delay,
                         input logic [31:0] rd);
    logic [31:0] exp_addr;
    logic        mis, exp_err;
    int          exp_lat, exp_req, cyc, req_cycles;
    exp_addr = b + i;
    mis      = (exp_addr % 4) != 0;
    exp_err  = mis || (ack_delay >= int'(TO));
    exp_lat  = mis ? 1 : ((ack_delay < int'(TO)) ? ack_delay + 2 : int'(TO) + 1);
    exp_req  = mis ? 0 : ((ack_delay < int'(TO)) ? ack_delay + 1 : int'(TO));

    start = 1'b1; is_store = st; base = b; imm = i; wdata = wd;
    step();
    cyc = 1;
    req_cycles = 0;
    while (!done && cyc <= 40) begin
      // Junk operands and starts while busy must be ignored.
      start = $urandom_range(0, 1); is_store = $urandom_range(0, 1);
      base = $urandom; imm = $urandom; wdata = $urandom;
      n_total++;
      if (busy !== 1'b1) $display("FAIL busy_access: got %b want 1", busy);
      else n_pass++;
      if (mem_req === 1'b1) begin
        req_cycles++;
        n_total++;
        if (mem_addr !== exp_addr) $display("FAIL mem_addr: got %h want %h", mem_addr, exp_addr);
        else n_pass++;
        n_total++;
        if (mem_we !== st) $display("FAIL mem_we: got %b want %b", mem_we, st);
        else n_pass++;
        if (st) begin
          n_total++;
          if (mem_wdata !== wd) $display("FAIL mem_wdata: got %h want %h", mem_wdata, wd);
          else n_pass++;
        end
        mem_ack   = (req_cycles - 1 == ack_delay);
        mem_rdata = mem_ack ? rd : $urandom;
      end else begin
        n_total++;
        $display("FAIL unexpected_state: mem_req=%b done=%b at cycle %0d", mem_req, done, cyc);
      end
      step();
      mem_ack = 1'b0;
      cyc++;
    end

    if (!exp_err && !st) model_rdata = rd;

    n_total++;
    if (done !== 1'b1) $display("FAIL done_timeout: done never seen within %0d cycles", cyc);
    else n_pass++;
    n_total++;
    if (cyc != exp_lat) $display("FAIL latency: got %0d want %0d", cyc, exp_lat);
    else n_pass++;
    n_total++;
    if (req_cycles != exp_req) $display("FAIL req_cycles: got %0d want %0d", req_cycles, exp_req);
    else n_pass++;
    n_total++;
    if (err !== exp_err) $display("FAIL err: got %b want %b", err, exp_err);
    else n_pass++;
    n_total++;
    if (mem_req !== 1'b0) $display("FAIL mem_req_done: got %b want 0", mem_req);
    else n_pass++;
    n_total++;
    if (rdata !== model_rdata) $display("FAIL rdata: got %h want %h", rdata, model_rdata);
    else n_pass++;

    // A start in the DONE cycle must not be accepted; stray ack ignored too.
    start = 1'b1; is_store = 1'b0; base = 32'h100; imm = 32'h0;
    mem_ack = 1'b1; mem_rdata = $urandom;
    step();
    start = 1'b0; mem_ack = 1'b0;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL start_in_done: busy=%b done=%b mem_req=%b want 000", busy, done, mem_req);
    else n_pass++;
    n_total++;
    if (rdata !== model_rdata) $display("FAIL rdata_hold: got %h want %h", rdata, model_rdata);
    else n_pass++;
  endtask

  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      mem_ack = $urandom_range(0, 1); mem_rdata = $urandom;
      step();
      mem_ack = 1'b0;
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || rdata !== model_rdata)
        $display("FAIL idle: busy=%b done=%b mem_req=%b rdata=%h want 0 0 0 %h",
                 busy, done, mem_req, rdata, model_rdata);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    is_store = 1'b1; base = 32'h40; imm = 32'h0; wdata = 32'hAAAA_5555;
    step();
    step();
    n_total++;
    if ({busy, done, err, mem_req, mem_we} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, mem_req, mem_we});
    else n_pass++;
    n_total++;
    if (mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0)
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, rdata);
    else n_pass++;
    reset = 1'b0; start = 1'b0; mem_ack = 1'b0;
    step();
    model_rdata = '0;
  endtask

  task automatic test_directed();
    run_txn(1'b0, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0, 0, 32'hDEAD_BEEF);
    run_txn(1'b1, 32'h0000_0020, 32'h0000_0008, 32'h1234_5678, 3, 32'h0BAD_0BAD);
    run_txn(1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0, 0, 32'h1111_1111);
    run_txn(1'b0, 32'h0000_0200, 32'h0000_0004, 32'h0, 10, 32'h2222_2222);
    run_txn(1'b0, 32'h0000_0200, 32'h0000_0004, 32'h0, 3, 32'h3333_3333);
  endtask

  task automatic test_wrap_and_reset();
    run_txn(1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0, 1, 32'h4444_4444);
    start = 1'b1; is_store = 1'b0; base = 32'hFFFF_FFF0; imm = 32'h20;
    step();
    start = 1'b0;
    step();
    n_total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10)
      $display("FAIL access2: mem_req=%b addr=%h want 1 00000010", mem_req, mem_addr);
    else n_pass++;
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    reset = 1'b0; mem_ack = 1'b0;
    model_rdata = '0;
    n_total++;
    if (mem_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_mid: mem_req=%b done=%b busy=%b want 000", mem_req, done, busy);
    else n_pass++;
    idle_gap(2);
    run_txn(1'b0, 32'h0000_0080, 32'h0000_0004, 32'h0, 2, 32'h6666_6666);
  endtask

  task automatic test_random();
    logic [31:0] b, i;
    for (int t = 0; t < 30; t++) begin
      b = $urandom;
      i = $urandom;
      if ($urandom_range(0, 3) != 0) i = i - ((b + i) % 4);
      run_txn($urandom_range(0, 1), b, i, $urandom, $urandom_range(0, 5), $urandom);
      idle_gap($urandom_range(0, 2));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; base = '0; imm = '0;
    wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_directed();
    test_wrap_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
